// File: rtl/cix_seq.sv
// cix_seq: multi-cycle bit-count sequencer (clz/ctz/clo/cto/popcount/zerocount), one chunk per cycle
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake; clz, ctz, inv, in sampled at accept
//   out_valid/out_ready   result handshake; out = count, zero = operand (after inv) was all zeros
module cix_seq #(
    parameter int ORDER     = 3,
    parameter int LOG_COUNT = 2
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    clz,
    input  logic                                    ctz,
    input  logic                                    inv,
    input  logic [(2**(ORDER+LOG_COUNT))-1:0]       in,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ORDER+LOG_COUNT:0]                out,
    output logic                                    zero
);
    localparam int C  = 2**ORDER;
    localparam int CW = ORDER + 1;
    localparam int AW = ORDER + LOG_COUNT + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic op_clz, op_ctz;
    logic [(2**(ORDER+LOG_COUNT))-1:0] data;
    logic [LOG_COUNT-1:0] idx, sel;
    logic [AW-1:0] acc;
    logic all_zero, null_op, chunk_zero, last;
    logic [C-1:0] chunk;
    logic [CW-1:0] lz, tz, nz, cnt;
    assign null_op = ~op_clz & ~op_ctz;
    // ~idx equals N-1-idx for a power-of-two chunk count
    assign sel = (op_clz & ~op_ctz) ? ~idx : idx;
    assign chunk = data[int'(sel)*C +: C];
    // a null op finishes after one cycle, so its zero flag covers the whole word at once
    assign chunk_zero = null_op ? (data == '0) : (chunk == '0);
    assign last = (&idx) | ((op_clz ^ op_ctz) & ~chunk_zero) | null_op;
    always_comb begin
        lz = CW'(C);
        tz = CW'(C);
        nz = '0;
        for (int i = 0; i < C; i++) begin
            if (chunk[i]) lz = CW'(C - 1 - i);
            if (!chunk[i]) nz = nz + CW'(1);
        end
        for (int i = C - 1; i >= 0; i--)
            if (chunk[i]) tz = CW'(i);
        cnt = (op_clz & op_ctz) ? nz : op_clz ? lz : op_ctz ? tz : '0;
    end
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_n   = state == IDLE ? (in_valid ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) :
                                    (out_ready ? IDLE : DONE);
        out       = out_valid ? acc : '0;
        zero      = out_valid & all_zero;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_clz   <= 1'b0;
            op_ctz   <= 1'b0;
            data     <= '0;
            idx      <= '0;
            acc      <= '0;
            all_zero <= 1'b0;
        end else if (in_valid & in_ready) begin
            op_clz   <= clz;
            op_ctz   <= ctz;
            data     <= inv ? ~in : in;
            idx      <= '0;
            acc      <= '0;
            all_zero <= 1'b1;
        end else if (state == RUN) begin
            acc      <= acc + {{LOG_COUNT{1'b0}}, cnt};
            all_zero <= all_zero & chunk_zero;
            idx      <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_cix_seq.sv
// tb_cix_seq: directed self-checking bench for cix_seq (W=32, 8-bit chunks)
module tb_cix_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_ready, clz = 1'b0, ctz = 1'b0, inv = 1'b0;
    logic [31:0] in = '0;
    logic out_valid, out_ready = 1'b0, zero;
    logic [5:0] out;
    int checks = 0;
    int failures = 0;
    cix_seq dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .clz(clz), .ctz(ctz), .inv(inv), .in(in), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .zero(zero)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic accept(input logic [2:0] op, input logic [31:0] v);
        @(negedge clock);
        {clz, ctz, inv} = op;
        in = v;
        in_valid = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        {clz, ctz, inv} = 3'b000;
        in = '0;
    endtask
    task automatic wait_done(input string tag, input int exp_edges, input logic [5:0] exp_out, input logic exp_zero);
        int k = 0;
        do begin
            @(posedge clock);
            k++;
            #1;
            if (!out_valid && k < exp_edges) chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
        end while (!out_valid && k < 10);
        chk({tag, "_latency"}, 32'(k), 32'(exp_edges));
        chk({tag, "_out"}, 32'(out), 32'(exp_out));
        chk({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    endtask
    task automatic handshake(input string tag);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask
    initial begin
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_zero", 32'(zero), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        accept(3'b100, 32'h0001_0000);
        wait_done("clz", 2, 6'd15, 1'b0);
        handshake("clz");
        accept(3'b010, 32'h0001_0000);
        wait_done("ctz", 3, 6'd16, 1'b0);
        handshake("ctz");
        accept(3'b111, 32'hF0F0_0001);
        wait_done("popc", 4, 6'd9, 1'b0);
        handshake("popc");
        accept(3'b110, 32'hF0F0_0001);
        wait_done("zcnt", 4, 6'd23, 1'b0);
        handshake("zcnt");
        accept(3'b100, 32'h0000_0000);
        wait_done("clz0", 4, 6'd32, 1'b1);
        handshake("clz0");
        accept(3'b011, 32'hFFFF_FFFF);
        wait_done("cto1", 4, 6'd32, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out", 32'(out), 32'd32);
            chk("bp_zero", 32'(zero), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        handshake("bp");
        accept(3'b010, 32'h0000_0080);
        wait_done("ctz_after_bp", 1, 6'd7, 1'b0);
        handshake("ctz_after_bp");
        accept(3'b000, 32'h1234_5678);
        wait_done("null", 1, 6'd0, 1'b0);
        handshake("null");
        accept(3'b111, 32'hFFFF_FFFF);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_zero", 32'(zero), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        accept(3'b101, 32'hFF7F_FFFF);
        wait_done("clo", 2, 6'd8, 1'b0);
        handshake("clo");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
